// File: rtl/audio_mixer_n.sv
// Time-multiplexed N-channel audio mixer: per-channel gain/mute, one MAC per clock after a
// sample strobe, then arithmetic scaling and saturation to a signed output word.
module audio_mixer_n #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IN_W       = 16,
  parameter int unsigned GAIN_W     = 4,
  parameter int unsigned GAIN_SHIFT = 3,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce_sample,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [NUM_CH-1:0]        ch_signed,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic                     clip_clr,
  output logic [OUT_W-1:0]         out_sample,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun
);

  localparam int unsigned PW = IN_W + GAIN_W + 1;
  localparam int unsigned AW = PW + $clog2(NUM_CH);
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [IW-1:0]        LastIdx = IW'(NUM_CH - 1);
  localparam logic signed [AW-1:0] MaxOut  = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MinOut  = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StSat} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic [NUM_CH*IN_W-1:0]     samp_q;
  logic [NUM_CH-1:0]          sgn_q;
  logic [NUM_CH*GAIN_W-1:0]   gain_q;
  logic [NUM_CH-1:0]          mute_q;
  logic [OUT_W-1:0]           out_q, out_d;
  logic                       valid_q, valid_d;
  logic                       clip_q, clip_d;
  logic                       ovr_q, ovr_d;
  logic                       accept;
  logic                       clip_set;
  logic                       ovr_set;

  logic [IN_W-1:0]            cur_raw;
  logic [GAIN_W-1:0]          cur_gain;
  logic                       cur_sgn;
  logic                       cur_mute;
  logic [IN_W-1:0]            cur_samp;
  logic signed [PW-1:0]       samp_ext;
  logic signed [PW-1:0]       gain_ext;
  logic signed [PW-1:0]       term;
  logic signed [AW-1:0]       term_ext;
  logic signed [AW-1:0]       scaled;

  // Channel multiplexer driven by the snapshot registers, never by the live inputs.
  always_comb begin
    cur_raw  = samp_q[IN_W-1:0];
    cur_gain = gain_q[GAIN_W-1:0];
    cur_sgn  = sgn_q[0];
    cur_mute = mute_q[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (idx_q == IW'(i)) begin
        cur_raw  = samp_q[i*IN_W +: IN_W];
        cur_gain = gain_q[i*GAIN_W +: GAIN_W];
        cur_sgn  = sgn_q[i];
        cur_mute = mute_q[i];
      end
    end
  end

  // Offset-binary to two's complement is just an MSB flip.
  assign cur_samp = {cur_raw[IN_W-1] ^ ~cur_sgn, cur_raw[IN_W-2:0]};
  assign samp_ext = PW'($signed(cur_samp));
  assign gain_ext = $signed({{(IN_W+1){1'b0}}, cur_gain});
  assign term     = cur_mute ? '0 : samp_ext * gain_ext;
  assign term_ext = AW'(term);
  assign scaled   = acc_q >>> GAIN_SHIFT;

  assign accept  = (state_q == StIdle) && ce_sample;
  assign ovr_set = (state_q != StIdle) && ce_sample;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    clip_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce_sample) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + term_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StSat;
        end
      end
      StSat: begin
        valid_d = 1'b1;
        state_d = StIdle;
        if (scaled > MaxOut) begin
          out_d    = MaxOut[OUT_W-1:0];
          clip_set = 1'b1;
        end else if (scaled < MinOut) begin
          out_d    = MinOut[OUT_W-1:0];
          clip_set = 1'b1;
        end else begin
          out_d = scaled[OUT_W-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
    // A set in the same cycle as a clear wins.
    clip_d = clip_set | (clip_q & ~clip_clr);
    ovr_d  = ovr_set | (ovr_q & ~clip_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      samp_q  <= '0;
      sgn_q   <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
      if (accept) begin
        samp_q <= ch_in;
        sgn_q  <= ch_signed;
        gain_q <= ch_gain;
        mute_q <= ch_mute;
      end
    end
  end

  assign out_sample = out_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != StIdle);
  assign clip       = clip_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_audio_mixer_n.sv
// Randomised and directed bench for audio_mixer_n, checked against an integer-arithmetic model.
module tb_audio_mixer_n;

  localparam int NCH = 4;
  localparam int IW  = 16;
  localparam int GW  = 4;
  localparam int GS  = 3;
  localparam int OW  = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                ce_sample;
  logic [NCH*IW-1:0]   ch_in;
  logic [NCH-1:0]      ch_signed;
  logic [NCH*GW-1:0]   ch_gain;
  logic [NCH-1:0]      ch_mute;
  logic                clip_clr;
  logic [OW-1:0]       out_sample;
  logic                out_valid;
  logic                busy;
  logic                clip;
  logic                overrun;

  int total = 0;
  int bad   = 0;

  audio_mixer_n #(
    .NUM_CH(NCH), .IN_W(IW), .GAIN_W(GW), .GAIN_SHIFT(GS), .OUT_W(OW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_sample  (ce_sample),
    .ch_in      (ch_in),
    .ch_signed  (ch_signed),
    .ch_gain    (ch_gain),
    .ch_mute    (ch_mute),
    .clip_clr   (clip_clr),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference: sum of sample*gain over unmuted channels, floor-divide by 2**GS, clamp.
  function automatic void model(input logic [63:0] ci, input logic [3:0] sg,
                                input logic [15:0] gn, input logic [3:0] mu,
                                output logic [15:0] o, output logic c);
    longint acc;
    longint v;
    longint s;
    acc = 0;
    for (int i = 0; i < NCH; i++) begin
      if (sg[i]) v = longint'($signed(ci[i*16 +: 16]));
      else       v = longint'(ci[i*16 +: 16]) - 32768;
      if (!mu[i]) acc = acc + v * longint'(gn[i*4 +: 4]);
    end
    s = acc >>> GS;
    c = 1'b0;
    if (s > 32767) begin
      o = 16'h7fff; c = 1'b1;
    end else if (s < -32768) begin
      o = 16'h8000; c = 1'b1;
    end else begin
      o = s[15:0];
    end
  endfunction

  // Starts a pass at the current negedge; returns the negedge count to out_valid (-1 on timeout)
  // and the busy level one cycle after acceptance. Leaves time at the out_valid cycle.
  task automatic do_pass(input logic [63:0] ci, input logic [3:0] sg, input logic [15:0] gn,
                         input logic [3:0] mu, output int lat, output logic b1);
    ch_in = ci; ch_signed = sg; ch_gain = gn; ch_mute = mu;
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    b1 = busy;
    lat = -1;
    for (int n = 0; n <= 20; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce_sample = 1'b0; clip_clr = 1'b0;
    ch_in = '0; ch_signed = '1; ch_gain = '0; ch_mute = '1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (out_sample !== 16'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out_sample); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip got=%b exp=0", clip); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_unity();
    int lat; logic b1;
    do_pass(64'h0000_0000_0000_1000, 4'hF, 16'h0008, 4'b1110, lat, b1);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL unity_busy_t1 got=%b exp=1", b1); end
    total++; if (lat != NCH + 1) begin bad++; $display("FAIL unity_latency got=%0d exp=%0d", lat, NCH + 1); end
    total++; if (out_sample !== 16'h1000) begin bad++; $display("FAIL unity_out got=%h exp=1000", out_sample); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL unity_clip got=%b exp=0", clip); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL unity_pulse got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL unity_idle got=%b exp=0", busy); end
    total++; if (out_sample !== 16'h1000) begin bad++; $display("FAIL unity_hold got=%h exp=1000", out_sample); end
  endtask

  task automatic test_gain();
    int lat; logic b1;
    do_pass(64'h0000_0000_0000_1000, 4'hF, 16'h000F, 4'b1110, lat, b1);
    total++; if (out_sample !== 16'h1E00) begin bad++; $display("FAIL gain15 got=%h exp=1e00", out_sample); end
    @(negedge clk);
    do_pass(64'h0000_0000_0000_FFFF, 4'hF, 16'h0001, 4'b1110, lat, b1);
    total++; if (out_sample !== 16'hFFFF) begin bad++; $display("FAIL floor_neg got=%h exp=ffff", out_sample); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int lat; logic b1;
    do_pass(64'h0000_0000_7000_7000, 4'hF, 16'h0088, 4'b1100, lat, b1);
    total++; if (out_sample !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fff", out_sample); end
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL sat_pos_clip got=%b exp=1", clip); end
    @(negedge clk);
    pulse_clr();
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL clip_clr got=%b exp=0", clip); end
    do_pass(64'h0000_0000_8000_8000, 4'hF, 16'h0088, 4'b1100, lat, b1);
    total++; if (out_sample !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h exp=8000", out_sample); end
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL sat_neg_clip got=%b exp=1", clip); end
    @(negedge clk);
    pulse_clr();
    // Clear held across the whole pass: the saturation set must still win.
    clip_clr = 1'b1;
    do_pass(64'h0000_0000_7000_7000, 4'hF, 16'h0088, 4'b1100, lat, b1);
    clip_clr = 1'b0;
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", clip); end
    @(negedge clk);
    pulse_clr();
    // Exact negative full scale is representable and must not clip.
    do_pass(64'h0000_0000_0000_8000, 4'hF, 16'h0008, 4'b1110, lat, b1);
    total++; if (out_sample !== 16'h8000 || clip !== 1'b0) begin
      bad++; $display("FAIL min_noclip got=%h/%b exp=8000/0", out_sample, clip);
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat; logic b1;
    pulse_clr();
    do_pass(64'h0000_0000_0000_0000, 4'b1011, 16'h0400, 4'b1011, lat, b1);
    total++; if (out_sample !== 16'hC000) begin bad++; $display("FAIL unsigned_zero got=%h exp=c000", out_sample); end
    @(negedge clk);
    do_pass(64'h0000_FFFF_0000_0000, 4'b1011, 16'h0800, 4'b1011, lat, b1);
    total++; if (out_sample !== 16'h7FFF) begin bad++; $display("FAIL unsigned_max got=%h exp=7fff", out_sample); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL unsigned_clip got=%b exp=0", clip); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int nvalid;
    pulse_clr();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    ch_in = 64'h0000_0000_0000_0100; ch_signed = 4'hF; ch_gain = 16'h0008; ch_mute = 4'b1110;
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    ch_in = 64'h0000_0000_0000_0200;
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    ch_in = 64'h0000_0000_0000_7777;
    nvalid = 0;
    for (int n = 0; n < 12; n++) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
    total++; if (nvalid != 1) begin bad++; $display("FAIL overrun_valids got=%0d exp=1", nvalid); end
    total++; if (out_sample !== 16'h0100) begin bad++; $display("FAIL overrun_out got=%h exp=0100", out_sample); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    pulse_clr();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid_pass();
    int nvalid; int lat; logic b1;
    logic [15:0] eo; logic ec;
    ch_in = 64'h0000_0000_0000_1234; ch_signed = 4'hF; ch_gain = 16'h0008; ch_mute = 4'b1110;
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (out_sample !== 16'h0) begin bad++; $display("FAIL midrst_out got=%h exp=0", out_sample); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
    total++; if (nvalid != 0) begin bad++; $display("FAIL midrst_valid got=%0d exp=0", nvalid); end
    do_pass(64'h0000_0000_0000_1234, 4'hF, 16'h0008, 4'b1110, lat, b1);
    model(64'h0000_0000_0000_1234, 4'hF, 16'h0008, 4'b1110, eo, ec);
    total++; if (lat != NCH + 1 || out_sample !== eo) begin
      bad++; $display("FAIL midrst_after got=%h lat=%0d exp=%h lat=%0d", out_sample, lat, eo, NCH + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic b1;
    logic [63:0] ci; logic [3:0] sg; logic [15:0] gn; logic [3:0] mu;
    logic [15:0] eo; logic ec;
    for (int k = 0; k < 40; k++) begin
      ci = {$urandom, $urandom};
      sg = 4'($urandom);
      gn = 16'($urandom);
      mu = 4'($urandom_range(0, 15)) & 4'($urandom);
      model(ci, sg, gn, mu, eo, ec);
      pulse_clr();
      do_pass(ci, sg, gn, mu, lat, b1);
      total++; if (lat != NCH + 1 || out_sample !== eo || clip !== ec) begin
        bad++;
        $display("FAIL rand%0d got=%h clip=%b lat=%0d exp=%h clip=%b lat=%0d",
                 k, out_sample, clip, lat, eo, ec, NCH + 1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_gain();
    test_saturation();
    test_unsigned();
    test_overrun();
    test_reset_mid_pass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
